app_reset_sequencer: RTL and testbench
======================================

Name: app_reset_sequencer

Overview:
- Sits directly downstream of the clock/reset decouple control registers. Consumes their level outputs `decouple` and `assert_reset`, and turns them into correctly ordered region controls:
  - a registered clock-enable for the application-region clock buffer (BUFGCE CE);
  - an active-low application reset.
- Guarantees three things:
  - reset is asserted while the clock is still running, before the clock is gated;
  - the clock is re-enabled before reset is released;
  - reset is held for a minimum pulse width.
- Exposes status bits for readback.

Parameters:
- GATE_SETTLE_CYCLES, 4: dwell cycles with the clock running and reset asserted, before gating and after ungating; must be >= 1.
- RESET_HOLD_CYCLES, 16: minimum cycles app_resetn is held low after the clock runs; must be >= 1.
- CNT_WIDTH, 8: dwell counter width; both cycle parameters must be <= 2^CNT_WIDTH.

Ports:
- aclk  input  1  clock; all logic is on the rising edge.
- aresetn  input  1  asynchronous, active-low reset.
- decouple_req  input  1  level; from the controller's decouple register.
- reset_req  input  1  level, active-high; from the controller's assert_reset register.
- clk_gate_en  output  1  registered; 1 = application clock running, 0 = gated.
- app_resetn  output  1  registered, active-low reset to the application region.
- seq_busy  output  1  registered; 1 whenever state != RUN.
- gated_status  output  1  registered; 1 only in state GATED.

Behaviour:
- Interface: one clock, aclk. aresetn is asynchronous and active-low. Inputs are synchronous to aclk, so they are not synchronised.
- Reset (asynchronous, on aresetn=0):
  - state = RST_HOLD, counter = RESET_HOLD_CYCLES-1.
  - app_resetn = 0, clk_gate_en = 1, seq_busy = 1, gated_status = 0.
  - Asserting aresetn mid-sequence, including in GATED, immediately forces this state; the clock resumes at once.
- Counter:
  - Loaded with N-1 on each state entry; decrements by 1 per cycle and saturates at 0.
  - "done" means counter == 0, so the minimum dwell is N cycles.
- All outputs are decoded from the next state and registered, so they change in the same cycle the state register changes.
- States and transitions (evaluated each rising edge; the first matching rule wins):
  - RUN: clk_gate_en=1, app_resetn=1.
    - decouple_req=1 -> PRE_GATE, load GATE_SETTLE.
    - else reset_req=1 -> RST_HOLD, load RESET_HOLD.
    - decouple takes priority when both inputs are high in the same cycle.
  - PRE_GATE: clk_gate_en=1, app_resetn=0.
    - When done -> GATED. decouple_req dropping during PRE_GATE does not abort; the sequence still passes through GATED.
  - GATED: clk_gate_en=0, app_resetn=0.
    - decouple_req=0 -> POST_GATE, load GATE_SETTLE.
    - reset_req is ignored.
  - POST_GATE: clk_gate_en=1, app_resetn=0.
    - decouple_req=1 -> PRE_GATE, reload.
    - else when done -> RST_HOLD, load RESET_HOLD.
  - RST_HOLD: clk_gate_en=1, app_resetn=0.
    - decouple_req=1 -> PRE_GATE, reload.
    - else when done and reset_req=0 -> RUN.
    - If reset_req stays high, remain in RST_HOLD indefinitely with the counter at 0.
- Invariants (must hold on every cycle):
  - clk_gate_en falls only on a cycle where app_resetn was already 0 for >= GATE_SETTLE_CYCLES cycles.
  - app_resetn rises only after clk_gate_en has been 1 for >= GATE_SETTLE_CYCLES + RESET_HOLD_CYCLES cycles.
  - clk_gate_en and app_resetn never change toward the "run" values in the same cycle.
- Latencies:
  - RUN to app_resetn=0: 1 cycle after the request is sampled.
  - decouple_req to clk_gate_en=0: 1 + GATE_SETTLE_CYCLES cycles.
  - A reset_req pulse shorter than RESET_HOLD_CYCLES still produces a low pulse of exactly RESET_HOLD_CYCLES.

Test Plan (defaults GATE_SETTLE_CYCLES=4, RESET_HOLD_CYCLES=16):
- Power-up: release aresetn with both requests at 0 -> app_resetn=0 for exactly 16 cycles, then 1; seq_busy falls in the same cycle; clk_gate_en stays 1 throughout.
- Short reset: in RUN, pulse reset_req for 1 cycle -> app_resetn low for exactly 16 cycles; clk_gate_en stays 1.
- Long reset: hold reset_req for 40 cycles -> app_resetn stays low until reset_req is sampled 0, then rises 1 cycle later.
- Decouple: in RUN, hold decouple_req high for 20 cycles -> app_resetn=0 at +1; clk_gate_en=0 at +5; gated_status=1 while gated. After decouple_req falls: clk_gate_en=1 at +1 after the fall, and app_resetn=1 after a further 4+16 cycles.
- Priorities and aborts:
  - decouple_req and reset_req rise in the same cycle -> PRE_GATE path taken.
  - decouple_req re-asserts during POST_GATE -> clk_gate_en returns to 0 after 4 more cycles.
- Async reset while GATED: drop aresetn -> clk_gate_en=1 and app_resetn=0 without waiting for a clock edge; after release, the 16-cycle hold occurs.

Source files
------------

// File: rtl/app_reset_sequencer.sv
// ---------------------------------------------------------------------------
// app_reset_sequencer
//
// Purpose:
//   Turns the level-style decouple / assert_reset controls into correctly
//   ordered controls for the application region. Reset is always asserted
//   while the clock is still running, and it is held for a settle period
//   before the clock buffer is gated. When the region is ungated, the clock
//   runs for a settle period plus a reset hold period before reset is
//   released. A software reset request of any length gives a reset pulse of
//   at least RESET_HOLD_CYCLES.
//
// Ports:
//   aclk          in   rising-edge clock for all logic
//   aresetn       in   asynchronous active-low reset
//   decouple_req  in   level, 1 = isolate and gate the application region
//   reset_req     in   level, 1 = hold the application region in reset
//   clk_gate_en   out  registered BUFGCE CE, 1 = application clock running
//   app_resetn    out  registered active-low application reset
//   seq_busy      out  registered, 1 whenever the sequencer is not in RUN
//   gated_status  out  registered, 1 only while the clock is gated
// ---------------------------------------------------------------------------
module app_reset_sequencer #(
  parameter int GATE_SETTLE_CYCLES = 4,
  parameter int RESET_HOLD_CYCLES  = 16,
  parameter int CNT_WIDTH          = 8
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic decouple_req,
  input  logic reset_req,
  output logic clk_gate_en,
  output logic app_resetn,
  output logic seq_busy,
  output logic gated_status
);

  // A dwell of N cycles is counted by loading N-1 and finishing at zero.
  localparam logic [CNT_WIDTH-1:0] GATE_LOAD = CNT_WIDTH'(GATE_SETTLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] HOLD_LOAD = CNT_WIDTH'(RESET_HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    RUN       = 3'd0,
    PRE_GATE  = 3'd1,
    GATED     = 3'd2,
    POST_GATE = 3'd3,
    RST_HOLD  = 3'd4
  } state_t;

  state_t                 r_state;
  state_t                 w_nextState;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic [CNT_WIDTH-1:0]   w_cntNext;
  logic                   w_cntDone;

  logic                   r_clkGateEn;
  logic                   r_appResetn;
  logic                   r_seqBusy;
  logic                   r_gatedStatus;
  logic                   w_clkGateEnNext;
  logic                   w_appResetnNext;
  logic                   w_seqBusyNext;
  logic                   w_gatedStatusNext;

  assign w_cntDone = (r_cnt == '0);

  // Next-state logic. Decouple wins over reset in every state that looks at
  // both, and once PRE_GATE is entered the sequence always goes through
  // GATED so the clock buffer never sees a half-finished gate request.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      RUN: begin
        if (decouple_req)     w_nextState = PRE_GATE;
        else if (reset_req)   w_nextState = RST_HOLD;
      end
      PRE_GATE: begin
        if (w_cntDone)        w_nextState = GATED;
      end
      GATED: begin
        if (!decouple_req)    w_nextState = POST_GATE;
      end
      POST_GATE: begin
        if (decouple_req)     w_nextState = PRE_GATE;
        else if (w_cntDone)   w_nextState = RST_HOLD;
      end
      RST_HOLD: begin
        if (decouple_req)                  w_nextState = PRE_GATE;
        else if (w_cntDone && !reset_req)  w_nextState = RUN;
      end
      default:                w_nextState = RST_HOLD;
    endcase
  end

  // Dwell counter: reloaded on every state entry with the dwell of the state
  // being entered, otherwise counts down and sticks at zero.
  always_comb begin
    w_cntNext = r_cnt;
    if (w_nextState != r_state) begin
      case (w_nextState)
        PRE_GATE, POST_GATE: w_cntNext = GATE_LOAD;
        RST_HOLD:            w_cntNext = HOLD_LOAD;
        default:             w_cntNext = '0;
      endcase
    end else if (!w_cntDone) begin
      w_cntNext = r_cnt - 1'b1;
    end
  end

  // Output decode from the next state, so the registered outputs move on
  // the same edge as the state register.
  always_comb begin
    w_clkGateEnNext   = (w_nextState != GATED);
    w_appResetnNext   = (w_nextState == RUN);
    w_seqBusyNext     = (w_nextState != RUN);
    w_gatedStatusNext = (w_nextState == GATED);
  end

  // State, counter and output registers. Reset ungates the clock at once so
  // the region sees a running clock for the whole reset hold.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state       <= RST_HOLD;
      r_cnt         <= HOLD_LOAD;
      r_clkGateEn   <= 1'b1;
      r_appResetn   <= 1'b0;
      r_seqBusy     <= 1'b1;
      r_gatedStatus <= 1'b0;
    end else begin
      r_state       <= w_nextState;
      r_cnt         <= w_cntNext;
      r_clkGateEn   <= w_clkGateEnNext;
      r_appResetn   <= w_appResetnNext;
      r_seqBusy     <= w_seqBusyNext;
      r_gatedStatus <= w_gatedStatusNext;
    end
  end

  assign clk_gate_en  = r_clkGateEn;
  assign app_resetn   = r_appResetn;
  assign seq_busy     = r_seqBusy;
  assign gated_status = r_gatedStatus;

endmodule

// File: tb/tb_app_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_app_reset_sequencer
//
// Directed bench for app_reset_sequencer with default parameters (settle 4,
// hold 16). Outputs are packed as {clk_gate_en, app_resetn, seq_busy,
// gated_status} and compared against hand-derived values 1 ns after each
// rising edge.
// ---------------------------------------------------------------------------
module tb_app_reset_sequencer;

  // Expected output patterns {clk_gate_en, app_resetn, seq_busy, gated_status}
  localparam logic [3:0] O_RUN   = 4'b1100;
  localparam logic [3:0] O_HOLD  = 4'b1010;
  localparam logic [3:0] O_GATED = 4'b0011;

  logic aclk;
  logic aresetn;
  logic decouple_req;
  logic reset_req;
  logic clk_gate_en;
  logic app_resetn;
  logic seq_busy;
  logic gated_status;

  int testCount = 0;
  int failCount = 0;

  app_reset_sequencer #(
    .GATE_SETTLE_CYCLES (4),
    .RESET_HOLD_CYCLES  (16),
    .CNT_WIDTH          (8)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .decouple_req (decouple_req),
    .reset_req    (reset_req),
    .clk_gate_en  (clk_gate_en),
    .app_resetn   (app_resetn),
    .seq_busy     (seq_busy),
    .gated_status (gated_status)
  );

  // 100 MHz clock
  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  // Drive both request levels at once
  task automatic applyStimulus(input logic dec, input logic rst);
    decouple_req = dec;
    reset_req    = rst;
  endtask

  // Advance to 1 ns past the next rising edge
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Compare the packed outputs against the expected pattern
  task automatic checkOutput(input string tag, input logic [3:0] expected);
    logic [3:0] observed;
    observed = {clk_gate_en, app_resetn, seq_busy, gated_status};
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  // Step n edges, checking the same pattern after each one
  task automatic holdCheck(input string tag, input int n, input logic [3:0] expected);
    for (int i = 0; i < n; i++) begin
      tick();
      checkOutput($sformatf("%s_%0d", tag, i), expected);
    end
  endtask

  initial begin
    aresetn = 1'b0;
    applyStimulus(1'b0, 1'b0);

    // Power-up reset state
    tick();
    tick();
    checkOutput("reset_state", O_HOLD);

    // Power-up: 16 cycles low from release, then RUN
    aresetn = 1'b1;
    holdCheck("powerup_low", 15, O_HOLD);
    tick();
    checkOutput("powerup_run", O_RUN);
    holdCheck("run_idle", 3, O_RUN);

    // Short reset: 1-cycle pulse still gives a 16-cycle low pulse
    applyStimulus(1'b0, 1'b1);
    tick();
    checkOutput("short_rst_assert", O_HOLD);
    applyStimulus(1'b0, 1'b0);
    holdCheck("short_rst_low", 15, O_HOLD);
    tick();
    checkOutput("short_rst_release", O_RUN);

    // Long reset: held 40 cycles, rises one edge after being sampled low
    applyStimulus(1'b0, 1'b1);
    holdCheck("long_rst_low", 40, O_HOLD);
    applyStimulus(1'b0, 1'b0);
    tick();
    checkOutput("long_rst_release", O_RUN);

    // Decouple held 20 cycles: 4 cycles of reset before gating
    applyStimulus(1'b1, 1'b0);
    holdCheck("dec_pregate", 4, O_HOLD);
    tick();
    checkOutput("dec_gated", O_GATED);
    holdCheck("dec_gated_hold", 5, O_GATED);
    // reset_req is ignored while gated
    applyStimulus(1'b1, 1'b1);
    holdCheck("dec_gated_rstreq", 3, O_GATED);
    applyStimulus(1'b1, 1'b0);
    holdCheck("dec_gated_tail", 7, O_GATED);
    // Release: clock back first, reset released 20 edges later
    applyStimulus(1'b0, 1'b0);
    tick();
    checkOutput("dec_ungate", O_HOLD);
    holdCheck("dec_post_hold", 19, O_HOLD);
    tick();
    checkOutput("dec_run", O_RUN);

    // Decouple dropped during PRE_GATE still passes through GATED
    applyStimulus(1'b1, 1'b0);
    tick();
    checkOutput("pulse_pregate", O_HOLD);
    applyStimulus(1'b0, 1'b0);
    holdCheck("pulse_pregate_hold", 3, O_HOLD);
    tick();
    checkOutput("pulse_gated", O_GATED);
    tick();
    checkOutput("pulse_ungate", O_HOLD);
    holdCheck("pulse_post_hold", 19, O_HOLD);
    tick();
    checkOutput("pulse_run", O_RUN);

    // Both requests in the same cycle: decouple path wins
    applyStimulus(1'b1, 1'b1);
    tick();
    checkOutput("prio_first", O_HOLD);
    applyStimulus(1'b1, 1'b0);
    holdCheck("prio_pregate", 3, O_HOLD);
    tick();
    checkOutput("prio_gated", O_GATED);

    // Re-assert decouple during POST_GATE: back to gated 4 edges later
    applyStimulus(1'b0, 1'b0);
    tick();
    checkOutput("abort_post1", O_HOLD);
    tick();
    checkOutput("abort_post2", O_HOLD);
    applyStimulus(1'b1, 1'b0);
    holdCheck("abort_pregate", 4, O_HOLD);
    tick();
    checkOutput("abort_gated", O_GATED);

    // Async reset while gated: clock resumes without an edge
    #2;
    aresetn = 1'b0;
    #1;
    checkOutput("async_rst_gated", O_HOLD);
    applyStimulus(1'b0, 1'b0);
    tick();
    checkOutput("async_rst_held", O_HOLD);
    aresetn = 1'b1;
    holdCheck("async_post_low", 15, O_HOLD);
    tick();
    checkOutput("async_post_run", O_RUN);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
